// File: rtl/or_decode_pkg.sv
// Opcode map, system-instruction field values and the decoded bundle
// shared by the OR1K decode stage and its skid buffer.
package or_decode_pkg;

    localparam logic [5:0] OP_J     = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h01;
    localparam logic [5:0] OP_BNF   = 6'h03;
    localparam logic [5:0] OP_BF    = 6'h04;
    localparam logic [5:0] OP_NOP   = 6'h05;
    localparam logic [5:0] OP_MOVHI = 6'h06;
    localparam logic [5:0] OP_SYS   = 6'h08;
    localparam logic [5:0] OP_RFE   = 6'h09;
    localparam logic [5:0] OP_JR    = 6'h11;
    localparam logic [5:0] OP_JALR  = 6'h12;
    localparam logic [5:0] OP_MACI  = 6'h13;
    localparam logic [5:0] OP_LWA   = 6'h1B;
    localparam logic [5:0] OP_LD    = 6'h20;
    localparam logic [5:0] OP_LWZ   = 6'h21;
    localparam logic [5:0] OP_LWS   = 6'h22;
    localparam logic [5:0] OP_LBZ   = 6'h23;
    localparam logic [5:0] OP_LBS   = 6'h24;
    localparam logic [5:0] OP_LHZ   = 6'h25;
    localparam logic [5:0] OP_LHS   = 6'h26;
    localparam logic [5:0] OP_ADDI  = 6'h27;
    localparam logic [5:0] OP_ADDIC = 6'h28;
    localparam logic [5:0] OP_ANDI  = 6'h29;
    localparam logic [5:0] OP_ORI   = 6'h2A;
    localparam logic [5:0] OP_XORI  = 6'h2B;
    localparam logic [5:0] OP_MULI  = 6'h2C;
    localparam logic [5:0] OP_MFSPR = 6'h2D;
    localparam logic [5:0] OP_SHI   = 6'h2E;
    localparam logic [5:0] OP_SFI   = 6'h2F;
    localparam logic [5:0] OP_MTSPR = 6'h30;
    localparam logic [5:0] OP_MAC   = 6'h31;
    localparam logic [5:0] OP_FPU   = 6'h32;
    localparam logic [5:0] OP_SWA   = 6'h33;
    localparam logic [5:0] OP_SD    = 6'h34;
    localparam logic [5:0] OP_SW    = 6'h35;
    localparam logic [5:0] OP_SB    = 6'h36;
    localparam logic [5:0] OP_SH    = 6'h37;
    localparam logic [5:0] OP_ALU   = 6'h38;
    localparam logic [5:0] OP_SF    = 6'h39;

    // inst[25:16] sub-codes inside the OP_SYS group
    localparam logic [9:0] SYS_FIELD   = 10'h000;
    localparam logic [9:0] TRAP_FIELD  = 10'h100;
    localparam logic [9:0] MSYNC_FIELD = 10'h200;
    localparam logic [9:0] PSYNC_FIELD = 10'h280;
    localparam logic [9:0] CSYNC_FIELD = 10'h300;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [3:0]  alu_op;
        logic [7:0]  fpu_op;
        logic        ill;
        logic        sys;
        logic        trap;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    typedef struct packed {
        logic rd;
        logic ra;
        logic rb;
    } reg_use_t;

    function automatic logic imm_zext(input logic [5:0] op);
        return op inside {OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic logic base_legal(
        input logic [5:0] op,
        input logic [9:0] sub
    );
        if (op == OP_SYS)
            return sub inside {SYS_FIELD, TRAP_FIELD, MSYNC_FIELD,
                               PSYNC_FIELD, CSYNC_FIELD};
        return op inside {OP_J, OP_JAL, OP_BNF, OP_BF, OP_NOP,
                          OP_MOVHI, OP_RFE, OP_JR, OP_JALR,
                          OP_MACI, OP_LWA, [OP_LD:OP_MAC],
                          [OP_SWA:OP_SF]};
    endfunction

    function automatic reg_use_t reg_use(input logic [5:0] op);
        reg_use_t u;
        u.rd = op inside {OP_MOVHI, OP_LWA, [OP_LD:OP_SHI],
                          OP_FPU, OP_ALU};
        u.ra = op inside {OP_MACI, OP_LWA, [OP_LD:OP_SFI],
                          [OP_MTSPR:OP_SF]};
        u.rb = op inside {OP_JR, OP_JALR, [OP_MTSPR:OP_SF]};
        return u;
    endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry skid FIFO; in_ready depends only on occupancy and stall,
// never on out_ready.
module decode_skid
    import or_decode_pkg::*;
#(
    parameter int W = DEC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign in_ready  = !stall && (cnt != 2'd2);
    assign out_valid = !stall && (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// OR1K decode stage: field extraction and legality check into a skid buffer.
// Define DECODE_FPU_EN to make ORFPX32 (opcode 0x32) legal and drive fpu_op_out.
module decode_pipe
    import or_decode_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [31:0]       inst_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    input  logic              flush_in,
    input  logic              exc_ack_in,
    output logic [REG_AW-1:0] reg_a_addr_out,
    output logic [REG_AW-1:0] reg_b_addr_out,
    output logic [REG_AW-1:0] reg_d_addr_out,
    output logic [31:0]       imm_out,
    output logic [5:0]        opcode_out,
    output logic [3:0]        alu_op_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              flag_ill_inst_out,
    output logic              flag_syscall_out,
    output logic              flag_trap_out,
    output logic [7:0]        fpu_op_out
);

    localparam int BUN_W = DEC_W + PC_W;
    // register-field bits that do not exist in a REG_AW-wide file
    localparam logic [4:0] HI_MASK = 5'(~((32'd1 << REG_AW) - 32'd1));

    typedef enum logic {
        RUN,
        HOLD
    } state_t;

    state_t            state;
    dec_t              dec;
    dec_t              head;
    logic [PC_W-1:0]   head_pc;
    logic [BUN_W-1:0]  in_bun;
    logic [BUN_W-1:0]  out_bun;
    logic [5:0]        op;
    logic [9:0]        sub;
    reg_use_t          ru;
    logic              fpu_legal;
    logic              reg_bad;
    logic              stall;
    logic              flagged;

    always_comb begin
        op         = inst_in[31:26];
        sub        = inst_in[25:16];
        ru         = reg_use(op);
        dec        = '0;
        dec.rd     = inst_in[25:21];
        dec.ra     = inst_in[20:16];
        dec.rb     = inst_in[15:11];
        dec.opcode = op;
        dec.alu_op = inst_in[3:0];
        dec.imm    = imm_zext(op) ? {16'h0000, inst_in[15:0]}
                                  : {{16{inst_in[15]}}, inst_in[15:0]};
`ifdef DECODE_FPU_EN
        fpu_legal  = (op == OP_FPU);
        dec.fpu_op = inst_in[7:0];
`else
        fpu_legal  = 1'b0;
        dec.fpu_op = 8'h00;
`endif
        reg_bad  = (ru.rd && |(dec.rd & HI_MASK))
                || (ru.ra && |(dec.ra & HI_MASK))
                || (ru.rb && |(dec.rb & HI_MASK));
        dec.ill  = !(base_legal(op, sub) || fpu_legal) || reg_bad;
        dec.sys  = !dec.ill && (op == OP_SYS) && (sub == SYS_FIELD);
        dec.trap = !dec.ill && !dec.sys
                && (op == OP_SYS) && (sub == TRAP_FIELD);
    end

    assign in_bun = {dec, pc_in};
    assign {head, head_pc} = out_bun;
    assign stall = (state == HOLD) || reset_in;
    assign flagged = head.ill || head.sys || head.trap;

    decode_skid #(
        .W(BUN_W)
    ) u_skid (
        .clk       (clk_in),
        .rst       (reset_in),
        .flush     (flush_in),
        .stall     (stall),
        .in_valid  (in_valid_in),
        .in_ready  (in_ready_out),
        .in_data   (in_bun),
        .out_valid (out_valid_out),
        .out_ready (out_ready_in),
        .out_data  (out_bun)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in || flush_in) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:
                    if (out_valid_out && out_ready_in && flagged)
                        state <= HOLD;
                HOLD:
                    if (exc_ack_in)
                        state <= RUN;
                default:
                    state <= RUN;
            endcase
        end
    end

    assign reg_a_addr_out    = head.ra[REG_AW-1:0];
    assign reg_b_addr_out    = head.rb[REG_AW-1:0];
    assign reg_d_addr_out    = head.rd[REG_AW-1:0];
    assign imm_out           = head.imm;
    assign opcode_out        = head.opcode;
    assign alu_op_out        = head.alu_op;
    assign pc_out            = head_pc;
    assign flag_ill_inst_out = head.ill;
    assign flag_syscall_out  = head.sys;
    assign flag_trap_out     = head.trap;
    assign fpu_op_out        = head.fpu_op;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed and randomized bench for decode_pipe against a queue-based
// model of the decode rules and the 2-entry/HOLD flow-control behaviour.
module tb_decode_pipe;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic        out_valid_out;
    logic        out_ready_in;
    logic        flush_in;
    logic        exc_ack_in;
    logic [4:0]  reg_a_addr_out;
    logic [4:0]  reg_b_addr_out;
    logic [4:0]  reg_d_addr_out;
    logic [31:0] imm_out;
    logic [5:0]  opcode_out;
    logic [3:0]  alu_op_out;
    logic [31:0] pc_out;
    logic        flag_ill_inst_out;
    logic        flag_syscall_out;
    logic        flag_trap_out;
    logic [7:0]  fpu_op_out;

    always #5 clk_in = ~clk_in;

    decode_pipe dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .inst_in           (inst_in),
        .pc_in             (pc_in),
        .in_valid_in       (in_valid_in),
        .in_ready_out      (in_ready_out),
        .out_valid_out     (out_valid_out),
        .out_ready_in      (out_ready_in),
        .flush_in          (flush_in),
        .exc_ack_in        (exc_ack_in),
        .reg_a_addr_out    (reg_a_addr_out),
        .reg_b_addr_out    (reg_b_addr_out),
        .reg_d_addr_out    (reg_d_addr_out),
        .imm_out           (imm_out),
        .opcode_out        (opcode_out),
        .alu_op_out        (alu_op_out),
        .pc_out            (pc_out),
        .flag_ill_inst_out (flag_ill_inst_out),
        .flag_syscall_out  (flag_syscall_out),
        .flag_trap_out     (flag_trap_out),
        .fpu_op_out        (fpu_op_out)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] imm;
        logic [5:0]  op;
        logic [3:0]  alu;
        logic [7:0]  fpu;
        logic        ill;
        logic        sys;
        logic        trap;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   hold = 1'b0;
    int   acc_cnt;
    int   n0;

    function automatic exp_t model(input logic [31:0] i,
                                   input logic [31:0] pc);
        exp_t       e;
        logic [5:0] op;
        logic [9:0] sub;
        logic       ok;
        op = i[31:26];
        sub = i[25:16];
        ok = (op inside {6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06,
                         6'h09, 6'h11, 6'h12, 6'h13, 6'h1B,
                         [6'h20:6'h31], [6'h33:6'h39]})
          || (op == 6'h08 && sub inside {10'h000, 10'h100, 10'h200,
                                         10'h280, 10'h300});
`ifdef DECODE_FPU_EN
        ok = ok || (op == 6'h32);
        e.fpu = i[7:0];
`else
        e.fpu = 8'h00;
`endif
        e.pc = pc;
        e.rd = i[25:21];
        e.ra = i[20:16];
        e.rb = i[15:11];
        e.imm = (op inside {6'h29, 6'h2A, 6'h2B}) ? 32'(i[15:0])
                                                 : 32'($signed(i[15:0]));
        e.op = op;
        e.alu = i[3:0];
        e.ill = !ok;
        e.sys = ok && op == 6'h08 && sub == 10'h000;
        e.trap = ok && op == 6'h08 && sub == 10'h100;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.pc = pc_out;
        o.rd = reg_d_addr_out;
        o.ra = reg_a_addr_out;
        o.rb = reg_b_addr_out;
        o.imm = imm_out;
        o.op = opcode_out;
        o.alu = alu_op_out;
        o.fpu = fpu_op_out;
        o.ill = flag_ill_inst_out;
        o.sys = flag_syscall_out;
        o.trap = flag_trap_out;
        return o;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: return r;
            1: return 32'h20000000;
            2: return 32'h21000000;
            3: return {6'h2A, r[25:0]};
            4: return {6'h32, r[25:0]};
            default: return {6'h27, r[25:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Check pre-edge outputs, clock once, then advance the model.
    task automatic cycle();
        exp_t o;
        logic rdy_exp;
        logic vld_exp;
        logic acc;
        logic emit;
        #3;
        rdy_exp = !reset_in && !hold && q.size() < 2;
        vld_exp = !reset_in && !hold && q.size() > 0;
        chk("in_ready", in_ready_out, rdy_exp);
        chk("out_valid", out_valid_out, vld_exp);
        if (vld_exp)
            chk("bundle", obs(), q[0]);
        acc = in_valid_in && rdy_exp;
        emit = vld_exp && out_ready_in;
        @(posedge clk_in);
        #1;
        if (reset_in || flush_in) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold && exc_ack_in)
                hold = 1'b0;
            if (emit) begin
                o = q.pop_front();
                if (o.ill || o.sys || o.trap)
                    hold = 1'b1;
            end
            if (acc)
                q.push_back(model(inst_in, pc_in));
        end
    endtask

    task automatic send1(input logic [31:0] i);
        inst_in = i;
        pc_in = $urandom();
        in_valid_in = 1'b1;
        out_ready_in = 1'b0;
        cycle();
        in_valid_in = 1'b0;
        #1;
    endtask

    task automatic drain();
        out_ready_in = 1'b1;
        cycle();
        out_ready_in = 1'b0;
    endtask

    task automatic ack();
        exc_ack_in = 1'b1;
        cycle();
        exc_ack_in = 1'b0;
    endtask

    initial begin
        reset_in = 1'b1;
        inst_in = '0;
        pc_in = '0;
        in_valid_in = 1'b0;
        out_ready_in = 1'b0;
        flush_in = 1'b0;
        exc_ack_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", in_ready_out, 1'b0);
        chk("rst_valid", out_valid_out, 1'b0);
        reset_in = 1'b0;
        #1;
        chk("post_rst_ready", in_ready_out, 1'b1);
        chk("post_rst_valid", out_valid_out, 1'b0);
        chk("post_rst_data", obs(), '0);

        // l.addi r2,r1,5
        send1(32'h9C410005);
        chk("addi_valid", out_valid_out, 1'b1);
        chk("addi_rd", reg_d_addr_out, 5'd2);
        chk("addi_ra", reg_a_addr_out, 5'd1);
        chk("addi_imm", imm_out, 32'h00000005);
        chk("addi_flags", {flag_ill_inst_out, flag_syscall_out,
                           flag_trap_out}, 3'b000);
        drain();

        send1(32'hA843F000);
        chk("ori_zext", imm_out, 32'h0000F000);
        drain();
        send1(32'h9C41F000);
        chk("addi_sext", imm_out, 32'hFFFFF000);
        drain();

        send1(32'h20000000);
        chk("sys_flag", flag_syscall_out, 1'b1);
        chk("sys_ill", flag_ill_inst_out, 1'b0);
        drain();
        inst_in = 32'h9C410007;
        in_valid_in = 1'b1;
        repeat (3) cycle();
        chk("hold_ready", in_ready_out, 1'b0);
        ack();
        #1;
        chk("ack_ready", in_ready_out, 1'b1);
        cycle();
        in_valid_in = 1'b0;
        drain();

        send1(32'h21000000);
        chk("trap_flag", flag_trap_out, 1'b1);
        drain();
        ack();

        send1(32'hC8000000);
`ifdef DECODE_FPU_EN
        chk("fpu_ill", flag_ill_inst_out, 1'b0);
`else
        chk("fpu_ill", flag_ill_inst_out, 1'b1);
`endif
        chk("fpu_op", fpu_op_out, 8'h00);
        drain();
        ack();

        // flush and exc_ack together while in HOLD
        send1(32'h20000000);
        drain();
        flush_in = 1'b1;
        exc_ack_in = 1'b1;
        cycle();
        flush_in = 1'b0;
        exc_ack_in = 1'b0;
        #1;
        chk("flush_ack_ready", in_ready_out, 1'b1);
        chk("flush_ack_valid", out_valid_out, 1'b0);

        // stalled output with a continuous input stream
        acc_cnt = 0;
        inst_in = {6'h27, 10'h061, 16'd100};
        in_valid_in = 1'b1;
        out_ready_in = 1'b0;
        repeat (4) begin
            n0 = q.size();
            cycle();
            if (q.size() > n0) begin
                acc_cnt++;
                inst_in = {6'h27, 10'h061, 16'(100 + acc_cnt)};
            end
        end
        chk("stall_accepted", acc_cnt, 2);
        out_ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n0 = q.size();
            cycle();
            inst_in = {6'h27, 10'h061, 16'(200 + k)};
        end
        in_valid_in = 1'b0;
        repeat (3) cycle();

        // flush with both entries full and an offered input
        out_ready_in = 1'b0;
        in_valid_in = 1'b1;
        inst_in = 32'h9C410011;
        cycle();
        inst_in = 32'h9C410012;
        cycle();
        inst_in = 32'h9C410013;
        flush_in = 1'b1;
        cycle();
        flush_in = 1'b0;
        in_valid_in = 1'b0;
        #1;
        chk("flush_valid", out_valid_out, 1'b0);
        send1(32'h9C410099);
        chk("post_flush_imm", imm_out, 32'h00000099);
        drain();

        // reset while an instruction is held
        send1(32'h9C410055);
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
        #1;
        chk("midrst_valid", out_valid_out, 1'b0);
        chk("midrst_ready", in_ready_out, 1'b1);

        for (int n = 0; n < 600; n++) begin
            in_valid_in = ($urandom_range(0, 3) != 0);
            out_ready_in = ($urandom_range(0, 3) != 0);
            exc_ack_in = ($urandom_range(0, 2) == 0);
            flush_in = ($urandom_range(0, 39) == 0);
            inst_in = rnd_inst();
            pc_in = $urandom();
            cycle();
        end

        in_valid_in = 1'b0;
        flush_in = 1'b0;
        out_ready_in = 1'b1;
        exc_ack_in = 1'b1;
        repeat (6) cycle();
        exc_ack_in = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
